scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter MAX_WIDTH, default 1080: largest accepted frame width in pixels.
REQ-002 Parameter MAX_HEIGHT, default 1080: largest accepted frame height in pixels.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 width  input  32  frame width; sampled only when a start is accepted.
REQ-007 height  input  32  frame height; sampled only when a start is accepted.
REQ-008 in_valid  input  1  upstream pixel valid.
REQ-009 in_ready  output  1  controller can accept a pixel.
REQ-010 in_r, in_g, in_b  input  8 each  upstream pixel channels.
REQ-011 abort  input  1  frame abort request; functional only with SCAN_ABORT_EN.
REQ-012 out_valid  output  1  registered pixel strobe toward the BMP writer.
REQ-013 out_row, out_col  output  11 each  raster position of the presented pixel.
REQ-014 out_r, out_g, out_b  output  8 each  registered pixel channels.
REQ-015 busy  output  1  high in SCAN and DONE states.
REQ-016 frame_done  output  1  one-cycle pulse on frame completion or abort.
REQ-017 cfg_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 FSM states: IDLE, SCAN, DONE; the encoding is implementation-defined.
REQ-019 IDLE: start with 1<=width<=MAX_WIDTH and 1<=height<=MAX_HEIGHT latches width/height into internal registers, clears the row/col counters and moves to SCAN next cycle.
REQ-020 IDLE: start with out-of-range width or height pulses cfg_err next cycle and stays in IDLE.
REQ-021 in_ready is 1 only in SCAN and is driven combinationally from state.
REQ-022 Transfer happens when in_valid and in_ready are both 1; no transfer leaves the counters and pixel outputs held.
REQ-023 On a transfer, the next cycle has out_valid=1, out_row/out_col equal to the pre-increment counters and out_r/g/b equal to in_r/g/b; latency is exactly 1 cycle.
REQ-024 out_valid is 0 in every cycle that follows a cycle without a transfer.
REQ-025 col increments per transfer; at col=width-1 it wraps to 0 and row increments.
REQ-026 Transfer of pixel (height-1, width-1) moves to DONE; no further in_ready in that frame.
REQ-027 DONE lasts one cycle, asserts frame_done, then returns to IDLE.
REQ-028 start while busy is ignored and produces no cfg_err.
REQ-029 Counter comparisons use the latched 32-bit width/height; row/col are 11-bit and never exceed MAX-1.
REQ-030 A 1x1 frame takes one transfer, then DONE.

Reset
REQ-031 RESET low immediately forces IDLE, with row=col=0 and out_valid=in_ready=busy=frame_done=cfg_err=0.
REQ-032 RESET low also clears out_row, out_col, out_r/g/b and the latched width/height to 0.
REQ-033 Reset mid-frame discards the frame and produces no frame_done pulse.

Configuration
REQ-034 Macro SCAN_ABORT_EN defined: abort=1 in SCAN moves to DONE next cycle (frame_done pulses) and the counters are cleared. An abort in the same cycle as a transfer lets that pixel be presented.
REQ-035 SCAN_ABORT_EN undefined: the abort input is ignored and no abort logic is synthesized.

Verification
REQ-036 width=4, height=2, start, in_valid held 1 -> 8 out_valid pulses with (row,col) sequence (0,0)..(0,3),(1,0)..(1,3), then frame_done 1 cycle after the last pixel.
REQ-037 width=1, height=1 -> one transfer, out_valid at (0,0), frame_done on the following cycle, then busy=0.
REQ-038 width=3, height=1, in_valid toggled 1,0,0,1,0,1 -> counters hold while in_valid=0; cols 0,1,2 are presented, each one cycle after its transfer.
REQ-039 start with width=0 or height=MAX_HEIGHT+1 -> cfg_err pulse, busy stays 0; start mid-frame -> no effect on counters.
REQ-040 RESET pulsed low after 3 pixels of a 4x2 frame -> all outputs 0 at once, no frame_done; a new start then scans from (0,0).
REQ-041 SCAN_ABORT_EN defined, abort at pixel 5 of 4x2 -> frame_done the next cycle, then IDLE; undefined -> abort ignored, 8 pixels are presented.

Source files
------------

// File: rtl/scan_ctrl.sv
// scan_ctrl: raster-scan controller that sits between a pixel source and a BMP writer.
// A start request with an in-range width/height opens a frame. Pixels are then
// accepted with a valid/ready handshake and presented one cycle later together
// with their (row, col) position. frame_done pulses once when the frame ends.
// Optional feature: define SCAN_ABORT_EN to let `abort` end a frame early.
// Without that macro the abort input is ignored and no abort logic is built.
module scan_ctrl #(
    parameter int MAX_WIDTH  = 1080,
    parameter int MAX_HEIGHT = 1080
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [31:0] width,
    input  logic [31:0] height,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        abort,
    output logic        out_valid,
    output logic [10:0] out_row,
    output logic [10:0] out_col,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] width_q;
    logic [31:0] height_q;
    logic [10:0] row;
    logic [10:0] col;
    logic        cfg_ok;
    logic        accept;
    logic        xfer;
    logic        last_col;
    logic        last_row;
    logic        abort_hit;

    // The row/col counters are 11 bits wide. They are widened to 32 bits here so
    // that the end-of-line and end-of-frame compares use the full latched size.
    assign cfg_ok   = (width  >= 32'd1) && (width  <= 32'(MAX_WIDTH)) &&
                      (height >= 32'd1) && (height <= 32'(MAX_HEIGHT));
    assign accept   = (state == S_IDLE) && start && cfg_ok;
    assign in_ready = (state == S_SCAN);
    assign busy     = (state == S_SCAN) || (state == S_DONE);
    assign xfer     = in_valid && in_ready;
    assign last_col = ({21'd0, col} == (width_q  - 32'd1));
    assign last_row = ({21'd0, row} == (height_q - 32'd1));

`ifdef SCAN_ABORT_EN
    assign abort_hit = (state == S_SCAN) && abort;
`else
    // The abort input is intentionally left unconnected in this build.
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    // Next-state decode for the IDLE -> SCAN -> DONE -> IDLE sequence.
    always_comb begin
        // NOTE: assign a default first, so that no path through the case statement leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_SCAN;
            S_SCAN: begin
                if (abort_hit)                        state_nxt = S_DONE;
                else if (xfer && last_col && last_row) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register. The pulse outputs are registered so that each lasts exactly one cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples values from before the edge.
            state      <= state_nxt;
            frame_done <= (state_nxt == S_DONE);
            cfg_err    <= (state == S_IDLE) && start && !cfg_ok;
        end
    end

    // Latch the frame size and advance the raster counters on each transfer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            width_q  <= 32'd0;
            height_q <= 32'd0;
            row      <= 11'd0;
            col      <= 11'd0;
        end else if (accept) begin
            width_q  <= width;
            height_q <= height;
            row      <= 11'd0;
            col      <= 11'd0;
        end else if (abort_hit) begin
            row <= 11'd0;
            col <= 11'd0;
        end else if (xfer) begin
            if (last_col) begin
                col <= 11'd0;
                row <= last_row ? 11'd0 : row + 11'd1;
            end else begin
                col <= col + 11'd1;
            end
        end
    end

    // Present each accepted pixel one cycle after its transfer. Between transfers the
    // position and pixel outputs hold their last values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid <= 1'b0;
            out_row   <= 11'd0;
            out_col   <= 11'd0;
            out_r     <= 8'd0;
            out_g     <= 8'd0;
            out_b     <= 8'd0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_row <= row;
                out_col <= col;
                out_r   <= in_r;
                out_g   <= in_g;
                out_b   <= in_b;
            end
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: scoreboard bench for scan_ctrl. A small reference model predicts
// handshake and frame behaviour. Each predicted pixel is queued when it is driven
// and is compared when the DUT presents it.
module tb_scan_ctrl;

    localparam int MAX_W = 1080;
    localparam int MAX_H = 1080;
`ifdef SCAN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_SCAN = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start = 1'b0;
    logic [31:0] width = 32'd0;
    logic [31:0] height = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_r = 8'd0;
    logic [7:0]  in_g = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic [10:0] out_row;
    logic [10:0] out_col;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [1:0]  m_state = M_IDLE;
    logic [31:0] m_w = 32'd0;
    logic [31:0] m_h = 32'd0;
    logic [31:0] m_row = 32'd0;
    logic [31:0] m_col = 32'd0;
    logic        exp_ov = 1'b0;
    logic        exp_fd = 1'b0;
    logic        exp_ce = 1'b0;
    logic [45:0] sb_q[$];

    scan_ctrl #(.MAX_WIDTH(MAX_W), .MAX_HEIGHT(MAX_H)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .abort(abort), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .busy(busy),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle. Inputs are driven at the negedge, the model steps, and the
    // registered outputs are compared at the next negedge.
    task automatic cycle(input logic s, input logic v, input logic a,
                         input logic [31:0] w, input logic [31:0] h);
        logic [1:0] nxt;
        logic       xf;
        start = s; in_valid = v; abort = a; width = w; height = h;
        in_r = 8'($urandom_range(0, 255));
        in_g = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
        #1;
        check("in_ready", in_ready, m_state == M_SCAN);
        check("busy", busy, m_state != M_IDLE);
        xf  = (m_state == M_SCAN) && v;
        nxt = m_state;
        if (xf) sb_q.push_back({m_row[10:0], m_col[10:0], in_r, in_g, in_b});
        exp_ce = 1'b0;
        case (m_state)
            M_IDLE: if (s) begin
                if (w >= 1 && w <= MAX_W && h >= 1 && h <= MAX_H) begin
                    m_w = w; m_h = h; m_row = 0; m_col = 0; nxt = M_SCAN;
                end else begin
                    exp_ce = 1'b1;
                end
            end
            M_SCAN: begin
                if (ABORT_EN && a) begin
                    nxt = M_DONE; m_row = 0; m_col = 0;
                end else if (xf) begin
                    if (m_col == m_w - 1) begin
                        m_col = 0;
                        if (m_row == m_h - 1) begin
                            m_row = 0; nxt = M_DONE;
                        end else begin
                            m_row = m_row + 1;
                        end
                    end else begin
                        m_col = m_col + 1;
                    end
                end
            end
            default: nxt = M_IDLE;
        endcase
        exp_ov  = xf;
        exp_fd  = (nxt == M_DONE);
        m_state = nxt;
        @(posedge CLK);
        @(negedge CLK);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov && sb_q.size() != 0)
            check("pixel", {out_row, out_col, out_r, out_g, out_b}, sb_q.pop_front());
        check("frame_done", frame_done, exp_fd);
        check("cfg_err", cfg_err, exp_ce);
    endtask

    // Asserts RESET asynchronously and checks that every output clears at once.
    task automatic do_reset();
        RESET = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pos", {out_row, out_col}, 0);
        check("rst_rgb", {out_r, out_g, out_b}, 0);
        m_state = M_IDLE; m_row = 0; m_col = 0; m_w = 0; m_h = 0;
        exp_ov = 0; exp_fd = 0; exp_ce = 0;
        sb_q.delete();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        RESET = 1'b0;
        do_reset();

        // 4x2 with in_valid held high: eight pixels, then frame_done.
        cycle(1, 0, 0, 4, 2);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);
        idle(2);

        // 1x1 frame.
        cycle(1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);

        // 3x1 frame with in_valid toggled 1,0,0,1,0,1.
        cycle(1, 0, 0, 3, 1);
        cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0); cycle(0, 1, 0, 0, 0);
        idle(3);

        // Rejected starts, including the boundaries just outside the range.
        cycle(1, 0, 0, 0, 2);
        idle(1);
        cycle(1, 0, 0, 4, MAX_H + 1);
        idle(1);
        cycle(1, 0, 0, MAX_W + 1, 1);
        cycle(1, 0, 0, 5, 0);
        idle(1);

        // A start while a frame is in progress must be ignored.
        cycle(1, 0, 0, 4, 2);
        cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 2, 1);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
        idle(2);

        // Reset after three pixels of a 4x2 frame, then rescan from (0,0).
        cycle(1, 0, 0, 4, 2);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        do_reset();
        idle(2);
        cycle(1, 0, 0, 4, 2);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);

        // Abort raised together with the fifth transfer of a 4x2 frame.
        cycle(1, 0, 0, 4, 2);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
        idle(2);

        // Random in_valid pattern on a 5x3 frame, with a bounded number of cycles.
        cycle(1, 0, 0, 5, 3);
        for (int i = 0; i < 200 && m_state != M_IDLE; i++)
            cycle(0, 1'($urandom_range(0, 1)), 0, 0, 0);
        check("rand_frame_ended", m_state, M_IDLE);
        idle(2);

        // Widest accepted line, two rows.
        cycle(1, 0, 0, MAX_W, 2);
        for (int i = 0; i < 2 * MAX_W + 3; i++) cycle(0, 1, 0, 0, 0);
        idle(2);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
